// File: rtl/riscv_perf_counter_bank.sv
// Performance-counter bank: NUM_EVENTS event-driven counters with per-counter
// enable, freeze, sticky overflow with interrupt, snapshot shadows and a
// single-cycle valid/ready host register port.
module riscv_perf_counter_bank #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] evt_i,
  input  logic                  bus_valid,
  input  logic                  bus_we,
  input  logic [7:0]            bus_addr,
  input  logic [CNT_WIDTH-1:0]  bus_wdata,
  output logic                  bus_ready,
  output logic [CNT_WIDTH-1:0]  bus_rdata,
  output logic                  irq_o
);

  localparam logic [6:0]           NUM_EV    = 7'(NUM_EVENTS);
  localparam logic [7:0]           ADDR_EN   = 8'h80;
  localparam logic [7:0]           ADDR_OVF  = 8'h81;
  localparam logic [7:0]           ADDR_IE   = 8'h82;
  localparam logic [7:0]           ADDR_CTRL = 8'h83;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);

  // Architectural state
  logic [CNT_WIDTH-1:0]  cnt_r    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  shadow_r [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] en_r;
  logic [NUM_EVENTS-1:0] ovf_r;
  logic [NUM_EVENTS-1:0] ie_r;
  logic                  freeze_r;
  logic                  ready_r;
  logic [CNT_WIDTH-1:0]  rdata_r;

  // Next-state and decode signals
  logic [CNT_WIDTH-1:0]  cnt_nxt_s [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_set_s;
  logic [NUM_EVENTS-1:0] ovf_nxt_s;
  logic [CNT_WIDTH-1:0]  rd_s;
  logic [5:0]            idx_s;
  logic                  wr_s;
  logic                  cnt_sel_s;
  logic                  shd_sel_s;
  logic                  clear_all_s;
  logic                  snapshot_s;

  assign idx_s       = bus_addr[5:0];
  assign wr_s        = bus_valid & bus_we;
  assign cnt_sel_s   = (bus_addr[7:6] == 2'b00) && ({1'b0, idx_s} < NUM_EV);
  assign shd_sel_s   = (bus_addr[7:6] == 2'b01) && ({1'b0, idx_s} < NUM_EV);
  assign clear_all_s = wr_s && (bus_addr == ADDR_CTRL) && bus_wdata[1];
  assign snapshot_s  = wr_s && (bus_addr == ADDR_CTRL) && bus_wdata[2];

  // Per-counter next value: clear_all beats host write beats event increment;
  // only a surviving increment from all-ones raises overflow.
  always_comb begin
    ovf_set_s = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (clear_all_s) begin
        cnt_nxt_s[i] = '0;
      end else if (wr_s && cnt_sel_s && (idx_s == 6'(i))) begin
        cnt_nxt_s[i] = bus_wdata;
      end else if (evt_i[i] && en_r[i] && !freeze_r) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        ovf_set_s[i] = (cnt_r[i] == '1);
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Overflow status: write-1-to-clear first, then new overflows so a set wins.
  always_comb begin
    ovf_nxt_s = ovf_r;
    if (wr_s && (bus_addr == ADDR_OVF)) begin
      ovf_nxt_s = ovf_r & ~bus_wdata[NUM_EVENTS-1:0];
    end else begin
      ovf_nxt_s = ovf_r;
    end
    ovf_nxt_s = ovf_nxt_s | ovf_set_s;
  end

  // Read mux over pre-update register contents; writes and idle cycles return 0.
  always_comb begin
    rd_s = '0;
    if (bus_valid && !bus_we) begin
      case (bus_addr[7:6])
        2'b00: begin
          for (int i = 0; i < NUM_EVENTS; i++) begin
            rd_s = rd_s | ({CNT_WIDTH{cnt_sel_s && (idx_s == 6'(i))}} & cnt_r[i]);
          end
        end
        2'b01: begin
          for (int i = 0; i < NUM_EVENTS; i++) begin
            rd_s = rd_s | ({CNT_WIDTH{shd_sel_s && (idx_s == 6'(i))}} & shadow_r[i]);
          end
        end
        2'b10: begin
          case (bus_addr)
            ADDR_EN:   rd_s[NUM_EVENTS-1:0] = en_r;
            ADDR_OVF:  rd_s[NUM_EVENTS-1:0] = ovf_r;
            ADDR_IE:   rd_s[NUM_EVENTS-1:0] = ie_r;
            ADDR_CTRL: rd_s[0] = freeze_r;
            default:   rd_s = '0;
          endcase
        end
        default: rd_s = '0;
      endcase
    end else begin
      rd_s = '0;
    end
  end

  // Live counters and snapshot shadows (shadows capture the pre-update value).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_r[i]    <= '0;
        shadow_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
        if (snapshot_s) begin
          shadow_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Configuration and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r     <= '1;
      ie_r     <= '0;
      ovf_r    <= '0;
      freeze_r <= 1'b0;
    end else begin
      ovf_r <= ovf_nxt_s;
      if (wr_s && (bus_addr == ADDR_EN)) begin
        en_r <= bus_wdata[NUM_EVENTS-1:0];
      end
      if (wr_s && (bus_addr == ADDR_IE)) begin
        ie_r <= bus_wdata[NUM_EVENTS-1:0];
      end
      if (wr_s && (bus_addr == ADDR_CTRL)) begin
        freeze_r <= bus_wdata[0];
      end
    end
  end

  // Host response: one cycle after every request, no stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      rdata_r <= '0;
    end else begin
      ready_r <= bus_valid;
      rdata_r <= rd_s;
    end
  end

  assign bus_ready = ready_r;
  assign bus_rdata = rdata_r;
  assign irq_o     = |(ovf_r & ie_r);

endmodule

// File: tb/tb_riscv_perf_counter_bank.sv
// Scoreboard bench for riscv_perf_counter_bank (8 counters, 8-bit width so
// wrap-around is reachable). Stimulus pushes expected responses computed by a
// behavioural model; a negedge monitor pops and compares.
module tb_riscv_perf_counter_bank;
  localparam int N = 8;
  localparam int W = 8;
  localparam int MODULUS = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] evt = '0;
  logic         bus_valid = 1'b0;
  logic         bus_we = 1'b0;
  logic [7:0]   bus_addr = '0;
  logic [W-1:0] bus_wdata = '0;
  logic         bus_ready;
  logic [W-1:0] bus_rdata;
  logic         irq_o;

  riscv_perf_counter_bank #(.NUM_EVENTS(N), .CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .evt_i(evt), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    bit is_read;
    int data;
    int addr;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural model of the register bank
  int m_cnt[N];
  int m_sh[N];
  int m_en, m_ovf, m_ie;
  bit m_frz;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_sh[i]  = 0;
    end
    m_en = 8'hFF; m_ovf = 0; m_ie = 0; m_frz = 1'b0;
  endtask

  function automatic int model_read(input logic [7:0] a);
    int ia;
    ia = int'(a);
    if (ia < N) return m_cnt[ia];
    if (ia >= 'h40 && ia < 'h40 + N) return m_sh[ia - 'h40];
    case (ia)
      'h80: return m_en;
      'h81: return m_ovf;
      'h82: return m_ie;
      'h83: return m_frz ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_irq();
    return (m_ovf & m_ie & 'hFF) != 0;
  endfunction

  task automatic model_step(input logic [N-1:0] e, input bit v, input bit we,
                            input logic [7:0] a, input logic [W-1:0] d);
    int old[N];
    int set;
    int ia;
    bit w;
    w = v && we;
    ia = int'(a);
    set = 0;
    for (int i = 0; i < N; i++) old[i] = m_cnt[i];
    for (int i = 0; i < N; i++) begin
      if (w && ia == 'h83 && d[1]) m_cnt[i] = 0;
      else if (w && ia == i) m_cnt[i] = int'(d);
      else if (e[i] && m_en[i] && !m_frz) begin
        if (old[i] == MODULUS - 1) set = set | (1 << i);
        m_cnt[i] = (old[i] + 1) % MODULUS;
      end
    end
    if (w && ia == 'h83 && d[2]) for (int i = 0; i < N; i++) m_sh[i] = old[i];
    if (w) begin
      case (ia)
        'h80: m_en = int'(d);
        'h81: m_ovf = m_ovf & ~int'(d) & 'hFF;
        'h82: m_ie = int'(d);
        'h83: m_frz = d[0];
        default: ;
      endcase
    end
    m_ovf = m_ovf | set;
  endtask

  // One clock of stimulus; expectation enters the queue once the request is taken.
  task automatic cycle(input logic [N-1:0] e, input bit v, input bit we,
                       input logic [7:0] a, input logic [W-1:0] d);
    exp_t x;
    evt = e; bus_valid = v; bus_we = we; bus_addr = a; bus_wdata = d;
    x.is_read = !we;
    x.data    = model_read(a);
    x.addr    = int'(a);
    @(posedge clk);
    if (v) exp_q.push_back(x);
    model_step(e, v, we, a, d);
    #1;
    evt = '0; bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    cycle('0, 1'b1, 1'b0, a, '0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [W-1:0] d);
    cycle('0, 1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input logic [N-1:0] e, input int n);
    for (int k = 0; k < n; k++) cycle(e, 1'b0, 1'b0, 8'h00, '0);
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) rd(8'(i));
    for (int i = 0; i < N; i++) rd(8'h40 + 8'(i));
    for (int i = 0; i < 4; i++) rd(8'h80 + 8'(i));
  endtask

  // Monitor: response timing, read data and interrupt level.
  always @(negedge clk) begin : monitor
    exp_t x;
    check("bus_ready", longint'(bus_ready), longint'(exp_q.size() > 0));
    if (bus_ready && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (x.is_read) check($sformatf("rdata[%02h]", x.addr), longint'(bus_rdata), longint'(x.data));
    end
    check("irq_o", longint'(irq_o), longint'(model_irq()));
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0]   a;
    logic [W-1:0] d;
    logic [N-1:0] e;
    bit           we;
    int           r;

    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and default cycle counting
    idle(8'h01, 100);
    read_all();

    // Wrap, overflow and interrupt
    wr(8'h02, 8'hFE);
    wr(8'h82, 8'h04);
    idle(8'h04, 2);
    rd(8'h02);
    rd(8'h81);
    wr(8'h81, 8'h04);
    idle('0, 2);
    rd(8'h81);

    // Write beats event; overflow set beats W1C
    cycle(8'h08, 1'b1, 1'b1, 8'h03, 8'h55);
    rd(8'h03);
    wr(8'h03, 8'hFF);
    wr(8'h82, 8'h08);
    cycle(8'h08, 1'b1, 1'b1, 8'h81, 8'h08);
    rd(8'h81);
    rd(8'h03);

    // Freeze, enable mask, snapshot
    wr(8'h83, 8'h01);
    idle(8'hFF, 10);
    read_all();
    wr(8'h83, 8'h00);
    wr(8'h80, 8'hFE);
    idle(8'hFF, 5);
    read_all();
    wr(8'h01, 8'd37);
    cycle(8'h02, 1'b1, 1'b1, 8'h83, 8'h04);
    rd(8'h41);
    rd(8'h01);

    // Clear_all beats events
    cycle(8'hFF, 1'b1, 1'b1, 8'h83, 8'h02);
    read_all();

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       a = 8'($urandom_range(0, N - 1));
      else if (r < 9)  a = 8'h40 + 8'($urandom_range(0, N - 1));
      else if (r < 13) a = 8'h80 + 8'($urandom_range(0, 3));
      else             a = 8'($urandom);
      we = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (we && a == 8'h83 && $urandom_range(0, 3) != 0) d = d & 8'hFD;
      e = 8'($urandom);
      cycle(e, 1'($urandom_range(0, 1)), we, a, d);
    end
    read_all();

    // Async reset with a response in flight
    cycle(8'hFF, 1'b1, 1'b0, 8'h00, '0);
    rst = 1'b1;
    #1;
    check("bus_ready_async_rst", longint'(bus_ready), 64'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    read_all();

    // Unmapped address
    rd(8'hF0);
    idle('0, 2);
    check("queue_drained", longint'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
